// File: rtl/multiboot_ctrl_if.sv
// Boot-request / warm-boot signal bundle for multiboot_ctrl.
// The slave modport is the controller side; master is the requester / testbench side.
interface multiboot_ctrl_if;
  logic       boot_req;
  logic [1:0] boot_image;
  logic       activity;
  logic       boot_ack;
  logic       busy;
  logic       image_err;
  logic       wdt_fired;
  logic       usb_pu;
  logic       wb_s1;
  logic       wb_s0;
  logic       wb_boot;

  modport master (
    output boot_req, boot_image, activity,
    input  boot_ack, busy, image_err, wdt_fired, usb_pu, wb_s1, wb_s0, wb_boot
  );

  modport slave (
    input  boot_req, boot_image, activity,
    output boot_ack, busy, image_err, wdt_fired, usb_pu, wb_s1, wb_s0, wb_boot
  );
endinterface

// File: rtl/multiboot_ctrl.sv
// Warm-boot sequencer: USB detach, image-select setup window, then SB_WARMBOOT strobe.
// Optional idle watchdog auto-boot is built when MULTIBOOT_WATCHDOG_EN is defined.
module multiboot_ctrl #(
  parameter int unsigned NUM_IMAGES    = 4,
  parameter int unsigned DEFAULT_IMAGE = 1,
  parameter int unsigned DETACH_CYCLES = 480000,
  parameter int unsigned SETUP_CYCLES  = 16,
  parameter int unsigned WDT_CYCLES    = 96000000
) (
  input logic             clk,
  input logic             reset_n,
  multiboot_ctrl_if.slave bus
);

  localparam int unsigned CntMax = (DETACH_CYCLES > SETUP_CYCLES) ? DETACH_CYCLES : SETUP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DetachLoad = CntW'(DETACH_CYCLES);
  localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntZero    = '0;
  localparam logic [2:0]      NumImg     = 3'(NUM_IMAGES);
  localparam logic [1:0]      DefImg     = 2'(DEFAULT_IMAGE);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDetach = 2'd1,
    StSetup  = 2'd2,
    StBoot   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      img_q, img_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            wdt_fired_q, wdt_fired_d;
  logic            pu_q, pu_d;
  logic            boot_q, boot_d;
  logic            wdt_expire;

`ifdef MULTIBOOT_WATCHDOG_EN
  localparam int unsigned      WdtW   = $clog2(WDT_CYCLES + 1);
  localparam logic [WdtW-1:0]  WdtMax = WdtW'(WDT_CYCLES);

  logic [WdtW-1:0] wdt_q, wdt_d;

  // Activity beats expiry in the same cycle; the count is frozen once the FSM leaves IDLE.
  always_comb begin
    wdt_d      = wdt_q;
    wdt_expire = 1'b0;
    if (state_q == StIdle) begin
      if (bus.activity) begin
        wdt_d = '0;
      end else if (wdt_q == WdtMax) begin
        wdt_expire = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_activity;
  assign unused_activity = bus.activity;
  assign wdt_expire      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    img_d       = img_q;
    ack_d       = 1'b0;
    err_d       = err_q;
    wdt_fired_d = wdt_fired_q;

    case (state_q)
      StIdle: begin
        // An external request takes priority over a simultaneous watchdog expiry.
        if (bus.boot_req) begin
          state_d = StDetach;
          cnt_d   = DetachLoad;
          ack_d   = 1'b1;
          if ({1'b0, bus.boot_image} < NumImg) begin
            img_d = bus.boot_image;
          end else begin
            img_d = DefImg;
            err_d = 1'b1;
          end
        end else if (wdt_expire) begin
          state_d     = StDetach;
          cnt_d       = DetachLoad;
          ack_d       = 1'b1;
          img_d       = DefImg;
          wdt_fired_d = 1'b1;
        end
      end
      StDetach: begin
        if (cnt_q == CntOne) begin
          state_d = StSetup;
          cnt_d   = SetupLoad;
        end else if (cnt_q != CntZero) begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSetup: begin
        if (cnt_q == CntOne) begin
          state_d = StBoot;
          cnt_d   = CntZero;
        end else if (cnt_q != CntZero) begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StBoot: begin
        state_d = StBoot;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered copies of next-state decodes, so they line up with state_q.
    busy_d = (state_d != StIdle);
    pu_d   = (state_d == StIdle);
    boot_d = (state_d == StBoot);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      img_q       <= DefImg;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wdt_fired_q <= 1'b0;
      pu_q        <= 1'b1;
      boot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      img_q       <= img_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      wdt_fired_q <= wdt_fired_d;
      pu_q        <= pu_d;
      boot_q      <= boot_d;
    end
  end

  assign bus.boot_ack  = ack_q;
  assign bus.busy      = busy_q;
  assign bus.image_err = err_q;
  assign bus.wdt_fired = wdt_fired_q;
  assign bus.usb_pu    = pu_q;
  assign bus.wb_s1     = img_q[1];
  assign bus.wb_s0     = img_q[0];
  assign bus.wb_boot   = boot_q;

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Scoreboard bench for multiboot_ctrl: a request-level model predicts each accepted boot,
// a negedge monitor checks ack/boot timing, latched image and sticky flags.
module tb_multiboot_ctrl;

  localparam int Num = 3;
  localparam int Def = 1;
  localparam int Det = 4;
  localparam int Stp = 2;
  localparam int Wdt = 20;

  typedef struct {
    int image;
    int err;
    int wdt;
    int ack_cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;

  exp_t exp_q[$];
  bit   mdl_idle;
  int   mdl_quiet;

  bit   ack_seen;
  bit   boot_seen;

  multiboot_ctrl_if bus ();

  multiboot_ctrl #(
    .NUM_IMAGES   (Num),
    .DEFAULT_IMAGE(Def),
    .DETACH_CYCLES(Det),
    .SETUP_CYCLES (Stp),
    .WDT_CYCLES   (Wdt)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sel();
    return int'({bus.wb_s1, bus.wb_s0});
  endfunction

  // Reference model: one acceptance per reset, out-of-range falls back to the default image,
  // optional watchdog fires after Wdt quiet idle cycles.
  initial begin
    exp_t e;
    int   img;
    bit   take;
    bit   wd;
    mdl_idle  = 1'b1;
    mdl_quiet = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mdl_idle  = 1'b1;
        mdl_quiet = 0;
        exp_q.delete();
      end else if (mdl_idle) begin
        take = 1'b0;
        wd   = 1'b0;
        img  = 0;
        if (bus.boot_req) begin
          take = 1'b1;
          img  = int'(bus.boot_image);
        end
`ifdef MULTIBOOT_WATCHDOG_EN
        else if (!bus.activity && mdl_quiet == Wdt) begin
          take = 1'b1;
          img  = Def;
          wd   = 1'b1;
        end
        if (bus.activity) mdl_quiet = 0;
        else if (mdl_quiet < Wdt) mdl_quiet++;
`endif
        if (take) begin
          e.image   = (img < Num) ? img : Def;
          e.err     = (img < Num) ? 0 : 1;
          e.wdt     = wd ? 1 : 0;
          e.ack_cyc = cyc + 1;
          exp_q.push_back(e);
          mdl_idle = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every boot_ack and tracks the resulting boot strobe.
  initial begin
    exp_t e;
    bit   pend;
    bit   locked;
    int   boot_at;
    int   cur_img;
    pend   = 1'b0;
    locked = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend      = 1'b0;
        locked    = 1'b0;
        ack_seen  = 1'b0;
        boot_seen = 1'b0;
      end else begin
        if (bus.boot_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("ack_cycle", cyc, e.ack_cyc);
            check("ack_image", sel(), e.image);
            check("ack_image_err", int'(bus.image_err), e.err);
            check("ack_wdt_fired", int'(bus.wdt_fired), e.wdt);
            check("ack_usb_pu", int'(bus.usb_pu), 0);
            check("ack_busy", int'(bus.busy), 1);
            pend     = 1'b1;
            locked   = 1'b1;
            cur_img  = e.image;
            boot_at  = e.ack_cyc + Det + Stp;
            ack_seen = 1'b1;
          end
        end else if (locked) begin
          check("sel_stable", sel(), cur_img);
        end
        if (pend && (bus.wb_boot || cyc >= boot_at)) begin
          check("boot_rise_cycle", bus.wb_boot ? cyc : -1, boot_at);
          pend      = 1'b0;
          boot_seen = bus.wb_boot;
        end
        if (!pend && !boot_seen && bus.wb_boot) check("unexpected_boot", 1, 0);
      end
    end
  end

  task automatic reset_now();
    reset_n        = 1'b0;
    bus.boot_req   = 1'b0;
    bus.activity   = 1'b0;
    #1;
    check("rst_usb_pu", int'(bus.usb_pu), 1);
    check("rst_wb_boot", int'(bus.wb_boot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_boot_ack", int'(bus.boot_ack), 0);
    check("rst_sel", sel(), Def);
    check("rst_image_err", int'(bus.image_err), 0);
    check("rst_wdt_fired", int'(bus.wdt_fired), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_now();
  endtask

  task automatic request(input logic [1:0] img);
    @(posedge clk);
    #1;
    bus.boot_req   = 1'b1;
    bus.boot_image = img;
    @(posedge clk);
    #1 bus.boot_req = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 10 && !ack_seen; i++) @(negedge clk);
    check("ack_seen", int'(ack_seen), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !boot_seen; i++) @(negedge clk);
    check("boot_seen", int'(boot_seen), 1);
    repeat (3) @(negedge clk);
    check("boot_held", int'(bus.wb_boot), 1);
    check("boot_usb_pu", int'(bus.usb_pu), 0);
    check("boot_busy", int'(bus.busy), 1);
  endtask

  initial begin
    int reqk;
    int len;
    reset_n        = 1'b0;
    bus.boot_req   = 1'b0;
    bus.boot_image = 2'd0;
    bus.activity   = 1'b0;
    cyc            = 0;
    total          = 0;
    bad            = 0;

    // Basic boot with image 2.
    do_reset();
    repeat (8) @(posedge clk);
    request(2'd2);
    wait_done();
    check("basic_sel", sel(), 2);

    // Out-of-range index falls back to the default image.
    do_reset();
    request(2'd3);
    wait_done();
    check("oor_image_err", int'(bus.image_err), 1);
    check("oor_sel", sel(), Def);

    // Request held across the whole sequence with the index changing midway.
    do_reset();
    @(posedge clk);
    #1;
    bus.boot_req   = 1'b1;
    bus.boot_image = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bus.boot_image = 2'd2;
    end
    bus.boot_req = 1'b0;
    wait_done();
    check("held_sel", sel(), 0);
    check("held_image_err", int'(bus.image_err), 0);

    // Reset during SETUP, then during BOOT; each time a fresh request completes.
    do_reset();
    request(2'd0);
    wait_ack();
    repeat (Det) @(posedge clk);
    #3;
    check("setup_busy", int'(bus.busy), 1);
    check("setup_wb_boot", int'(bus.wb_boot), 0);
    reset_now();
    request(2'd1);
    wait_done();
    @(posedge clk);
    #3;
    check("pre_rst_wb_boot", int'(bus.wb_boot), 1);
    reset_now();
    request(2'd2);
    wait_done();
    check("after_rst_sel", sel(), 2);

`ifdef MULTIBOOT_WATCHDOG_EN
    // Quiet idle: the watchdog boots the default image.
    do_reset();
    wait_done();
    check("wdt_fired_set", int'(bus.wdt_fired), 1);
    check("wdt_sel", sel(), Def);

    // Periodic activity keeps the watchdog from firing.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 bus.activity = (i % 15 == 14);
    end
    bus.activity = 1'b0;
    check("kick_busy", int'(bus.busy), 0);
    check("kick_wb_boot", int'(bus.wb_boot), 0);

    // boot_req in the expiry cycle wins.
    do_reset();
    for (int i = 0; i < 40 && mdl_quiet != Wdt; i++) @(posedge clk);
    #1;
    check("expiry_reached", mdl_quiet, Wdt);
    bus.boot_req   = 1'b1;
    bus.boot_image = 2'd0;
    @(posedge clk);
    #1 bus.boot_req = 1'b0;
    wait_done();
    check("coll_wdt_fired", int'(bus.wdt_fired), 0);
    check("coll_sel", sel(), 0);

    // activity in the expiry cycle wins.
    do_reset();
    for (int i = 0; i < 40 && mdl_quiet != Wdt; i++) @(posedge clk);
    #1;
    check("expiry_reached2", mdl_quiet, Wdt);
    bus.activity = 1'b1;
    @(posedge clk);
    #1 bus.activity = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("act_coll_busy", int'(bus.busy), 0);
`else
    // No watchdog: long idle never boots.
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    check("nowdt_busy", int'(bus.busy), 0);
    check("nowdt_wb_boot", int'(bus.wb_boot), 0);
    check("nowdt_wdt_fired", int'(bus.wdt_fired), 0);
`endif

    // Randomized: one request at a random point amid random activity.
    for (int it = 0; it < 20; it++) begin
      do_reset();
      len  = int'($urandom_range(30, 5));
      reqk = int'($urandom_range(len + 8, 0));
      for (int k = 0; k < len; k++) begin
        @(posedge clk);
        #1;
        bus.activity   = ($urandom_range(3, 0) == 0);
        bus.boot_req   = (k == reqk) || ($urandom_range(7, 0) == 0 && k > reqk);
        bus.boot_image = 2'($urandom_range(3, 0));
      end
      bus.boot_req = 1'b0;
      bus.activity = 1'b0;
      if (!mdl_idle) begin
        wait_done();
      end else begin
        check("rand_idle_busy", int'(bus.busy), 0);
      end
    end

    check("leftover_expect", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiboot_ctrl.md
# multiboot_ctrl

- Parametrised warm-boot sequencer that replaces a fixed SB_WARMBOOT hookup.
- Accepts a boot request for any of up to four iCE40 multiboot images.
- Detaches USB by releasing the pull-up for a programmable time, presents the image select bits for a setup window, then asserts the warm-boot strobe.
- Sits in the bootloader top between `tinyfpga_bootloader` and the `SB_WARMBOOT` primitive. It also drives the USB pull-up pin.

## Interface

**Parameters**
- `NUM_IMAGES`, 4: number of selectable images, 2..4.
- `DEFAULT_IMAGE`, 1: image used for out-of-range requests and watchdog boots. Must be < `NUM_IMAGES`.
- `DETACH_CYCLES`, 480000: cycles `usb_pu` is held low before setup. Range ≥1.
- `SETUP_CYCLES`, 16: cycles `wb_s1`/`wb_s0` are stable before `wb_boot` rises. Range ≥1.
- `WDT_CYCLES`, 96000000: idle cycles without `activity` before an automatic boot. Range ≥1. Used only with `MULTIBOOT_WATCHDOG_EN`.

**Ports**
- `clk` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `boot_req` input 1: request a warm boot. Sampled only in IDLE.
- `boot_image` input 2: image index, sampled with `boot_req`.
- `activity` input 1: watchdog kick, e.g. any USB/SPI transaction.
- `boot_ack` output 1: one-cycle pulse when a request is accepted.
- `busy` output 1: high in every state except IDLE.
- `image_err` output 1: sticky; set when an accepted index is ≥ `NUM_IMAGES`.
- `wdt_fired` output 1: sticky; set when the watchdog launched the boot.
- `usb_pu` output 1: USB D+ pull-up enable.
- `wb_s1`, `wb_s0` outputs 1 each: to `SB_WARMBOOT` S1/S0.
- `wb_boot` output 1: to `SB_WARMBOOT` BOOT.

## Operation

**States:** IDLE, DETACH, SETUP, BOOT. The state register is binary encoded.

**Reset values:**
- state = IDLE
- `usb_pu` = 1
- `wb_boot` = 0
- `{wb_s1,wb_s0}` = `DEFAULT_IMAGE`
- `boot_ack` = 0, `busy` = 0, `image_err` = 0, `wdt_fired` = 0
- all counters = 0

**IDLE**
- On `boot_req`=1: latch the image, load the phase counter, go to DETACH, pulse `boot_ack`.
- Image latched is `boot_image` if < `NUM_IMAGES`. Otherwise it is `DEFAULT_IMAGE`, and `image_err` is set.

**DETACH**
- `usb_pu` = 0.
- `{wb_s1,wb_s0}` = latched image; it stays at this value until reset.
- After `DETACH_CYCLES` cycles, go to SETUP.

**SETUP**
- `usb_pu` stays 0.
- After `SETUP_CYCLES` cycles, go to BOOT.

**BOOT**
- Terminal state. `wb_boot` = 1 and `usb_pu` = 0, held until reset.
- In hardware the FPGA reconfigures.

**Counters**
- One down-counter, width `$clog2(max(DETACH_CYCLES,SETUP_CYCLES)+1)`.
- It loads the phase length on entry to each phase and advances the state when it reaches 1.
- No wrap: the counter is never decremented at 0.

**Boundary rules**
- `boot_req` outside IDLE is ignored: no ack, no relatch, no `image_err` update.
- `boot_req` held high across states causes exactly one acceptance.
- `reset_n` asserted in any state, including BOOT, immediately forces all reset values. This release of `wb_boot` is asynchronous.
- `activity` has no effect outside IDLE.

## Timing

- `boot_req` high in IDLE during cycle N:
  - `boot_ack`=1, `busy`=1, `usb_pu`=0 and `{wb_s1,wb_s0}` valid during cycle N+1.
  - `boot_ack` returns to 0 in cycle N+2.
- SETUP is entered at N+1+`DETACH_CYCLES`.
- `wb_boot` rises at N+1+`DETACH_CYCLES`+`SETUP_CYCLES`.
- `wb_s1`/`wb_s0` are stable for at least `SETUP_CYCLES` cycles before `wb_boot` rises, and do not change afterward.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

**`MULTIBOOT_WATCHDOG_EN` defined:**
- A watchdog counter of width `$clog2(WDT_CYCLES+1)` increments every cycle in IDLE.
- It clears on `activity`=1. It saturates and is not used outside IDLE.
- When the count reaches `WDT_CYCLES`, an internal request for `DEFAULT_IMAGE` is accepted exactly as `boot_req` would be, and `wdt_fired` is set.
- If `boot_req` and expiry occur in the same cycle, `boot_req` wins: its image is used and `wdt_fired` stays 0.
- If `activity` and expiry occur in the same cycle, `activity` wins: the counter clears and no boot occurs.

**`MULTIBOOT_WATCHDOG_EN` undefined:**
- No watchdog logic is built.
- `activity` is ignored and `wdt_fired` is tied 0.

## Test plan

Bench parameters: `DETACH_CYCLES`=4, `SETUP_CYCLES`=2, `WDT_CYCLES`=20, `NUM_IMAGES`=3, `DEFAULT_IMAGE`=1.

1. Basic boot. Reset, then `boot_req` with `boot_image`=2 at cycle 10.
   - Cycle 11: `boot_ack` pulses and `usb_pu`=0.
   - `{wb_s1,wb_s0}`=2'b10 from cycle 11.
   - `wb_boot`=1 from cycle 17 and held.
2. Out-of-range index. `boot_req` with `boot_image`=3.
   - `image_err`=1 and `{wb_s1,wb_s0}`=2'b01.
   - Sequence timing is identical to scenario 1.
3. Requests while busy. `boot_req` held high for 10 cycles with the index changing 0→2 mid-sequence.
   - Exactly one `boot_ack`; the image stays 0.
4. Reset mid-sequence. `reset_n` pulsed low during SETUP, and again during BOOT.
   - Each time: `usb_pu`=1, `wb_boot`=0, `busy`=0 immediately.
   - A new request afterwards completes normally.
5. Watchdog (macro defined). No `activity` for 20 IDLE cycles.
   - Auto-boot with image 1 and `wdt_fired`=1.
   - Repeat with `activity` pulsed every 15 cycles: no boot ever occurs.
6. Watchdog collisions (macro defined).
   - `boot_req` with image 0 in the expiry cycle: image 0 boots, `wdt_fired`=0.
   - With the macro undefined: no boot after 100 idle cycles.
